// File: rtl/ctl_pkg.sv
// Shared definitions for the ctl_seq control sequencer: states, opcode map,
// datapath select encodings and the opcode classifier.
package ctl_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_LD,
    S_ST,
    S_LI,
    S_JZ,
    S_HALT
  } state_e;

  // Non-ALU opcodes sit directly above the ALU range, at ALU_OPS + offset.
  localparam int unsigned OFS_LD  = 0;
  localparam int unsigned OFS_ST  = 1;
  localparam int unsigned OFS_LI  = 2;
  localparam int unsigned OFS_JZ  = 3;
  localparam int unsigned OFS_SYS = 4;

  localparam logic [1:0] ADDR_PC   = 2'd0;
  localparam logic [1:0] ADDR_PC1  = 2'd1;
  localparam logic [1:0] ADDR_REGB = 2'd2;

  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_MEM = 1'b1;

  typedef enum logic [2:0] {
    OPC_ALU,
    OPC_LD,
    OPC_ST,
    OPC_LI,
    OPC_JZ,
    OPC_SYS,
    OPC_BAD
  } op_class_e;

  function automatic op_class_e classify(input int unsigned op,
                                         input int unsigned alu_ops);
    if (op < alu_ops)                  return OPC_ALU;
    else if (op == alu_ops + OFS_LD)   return OPC_LD;
    else if (op == alu_ops + OFS_ST)   return OPC_ST;
    else if (op == alu_ops + OFS_LI)   return OPC_LI;
    else if (op == alu_ops + OFS_JZ)   return OPC_JZ;
    else if (op == alu_ops + OFS_SYS)  return OPC_SYS;
    else                               return OPC_BAD;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired fires in the wait cycle that
// brings the count to MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, clr, run};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] r_cnt;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk) begin
        if (reset || clr) begin
          r_cnt <= '0;
        end else if (run) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign expired = run && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/ctl_seq.sv
// Multicycle control sequencer: fetch/decode/execute FSM driving PC, IR,
// register file, ALU and a req/ready memory port with a bus-error timeout.
module ctl_seq #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned REGW        = 6,
  parameter int unsigned OPW         = 4,
  parameter int unsigned ALU_OPS     = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ir,
  input  logic             a_zero,
  input  logic             mem_ready,
  output logic             pc_reset,
  output logic             pc_inc,
  output logic             pc_inc2,
  output logic             pc_load,
  output logic             ir_load,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_addr_sel,
  output logic [REGW-1:0]  reg_raddr_a,
  output logic [REGW-1:0]  reg_raddr_b,
  output logic             reg_we,
  output logic             reg_wsel,
  output logic [OPW-1:0]   alu_op,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err
);
  import ctl_pkg::*;

  generate
    if (OPW + 2 * REGW > WIDTH) begin : g_bad_cfg
      $error("ctl_seq: OPW + 2*REGW must not exceed WIDTH");
    end
  endgenerate

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  logic   r_bus_err;

  logic [OPW-1:0]  w_op;
  logic [REGW-1:0] w_rd;
  logic [REGW-1:0] w_rs;

  logic       w_mem_state;
  logic       w_expired;
  logic       w_clr;
  logic       w_pc_reset, w_pc_inc, w_pc_inc2, w_pc_load, w_ir_load;
  logic       w_mem_we, w_reg_we, w_reg_wsel;
  logic [1:0] w_addr_sel;
  logic [OPW-1:0] w_alu_op;
  logic       w_set_illegal, w_set_bus_err;

  assign w_op = ir[WIDTH-1 -: OPW];
  assign w_rd = ir[2*REGW-1:REGW];
  assign w_rs = ir[REGW-1:0];

  // Request is a pure function of state, so it stays stable until ready.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_LD) ||
                       (r_state == S_ST)    || (r_state == S_LI);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_clr),
    .run     (w_mem_state && !mem_ready),
    .expired (w_expired)
  );

  assign w_clr = (w_next != r_state) || (w_mem_state && mem_ready);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_next        = r_state;
    w_pc_reset    = 1'b0;
    w_pc_inc      = 1'b0;
    w_pc_inc2     = 1'b0;
    w_pc_load     = 1'b0;
    w_ir_load     = 1'b0;
    w_mem_we      = 1'b0;
    w_addr_sel    = ADDR_PC;
    w_reg_we      = 1'b0;
    w_reg_wsel    = WSEL_ALU;
    w_alu_op      = '0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;

    case (r_state)
      S_RESET: begin
        w_pc_reset = 1'b1;
        w_next     = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (classify(32'(w_op), ALU_OPS))
          OPC_ALU: w_next = S_ALU;
          OPC_LD:  w_next = S_LD;
          OPC_ST:  w_next = S_ST;
          OPC_LI:  w_next = S_LI;
          OPC_JZ:  w_next = S_JZ;
          OPC_SYS: w_next = S_HALT;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_ALU: begin
        w_alu_op = w_op;
        w_reg_we = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = S_FETCH;
      end
      S_LD: begin
        w_addr_sel = ADDR_REGB;
        if (mem_ready) begin
          w_reg_we   = 1'b1;
          w_reg_wsel = WSEL_MEM;
          w_pc_inc   = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_ST: begin
        w_addr_sel = ADDR_REGB;
        w_mem_we   = 1'b1;
        if (mem_ready) begin
          w_pc_inc = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_LI: begin
        w_addr_sel = ADDR_PC1;
        if (mem_ready) begin
          w_reg_we   = 1'b1;
          w_reg_wsel = WSEL_MEM;
          w_pc_inc2  = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_JZ: begin
        w_pc_load = a_zero;
        w_pc_inc  = !a_zero;
        w_next    = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RESET;
    endcase

    if (w_expired) begin
      w_set_bus_err = 1'b1;
      w_next        = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  // All outputs are forced low while reset is held, including mid-access.
  assign pc_reset     = !reset && w_pc_reset;
  assign pc_inc       = !reset && w_pc_inc;
  assign pc_inc2      = !reset && w_pc_inc2;
  assign pc_load      = !reset && w_pc_load;
  assign ir_load      = !reset && w_ir_load;
  assign mem_req      = !reset && w_mem_state;
  assign mem_we       = !reset && w_mem_we;
  assign mem_addr_sel = reset ? 2'd0 : w_addr_sel;
  assign reg_raddr_a  = reset ? '0 : w_rd;
  assign reg_raddr_b  = reset ? '0 : w_rs;
  assign reg_we       = !reset && w_reg_we;
  assign reg_wsel     = !reset && w_reg_wsel;
  assign alu_op       = reset ? '0 : w_alu_op;
  assign halted       = !reset && (r_state == S_HALT);
  assign illegal      = !reset && r_illegal;
  assign bus_err      = !reset && r_bus_err;

endmodule

// File: tb/tb_ctl_seq.sv
// Directed bench for ctl_seq: the stimulus pushes hand-computed per-cycle
// output vectors into a queue, a negedge monitor pops and compares them.
module tb_ctl_seq;

  typedef struct packed {
    logic       pc_reset;
    logic       pc_inc;
    logic       pc_inc2;
    logic       pc_load;
    logic       ir_load;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic [5:0] raddr_a;
    logic [5:0] raddr_b;
    logic       reg_we;
    logic       wsel;
    logic [3:0] alu_op;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        a_zero;
  logic        mem_ready;

  logic       pc_reset, pc_inc, pc_inc2, pc_load, ir_load, mem_req, mem_we;
  logic [1:0] mem_addr_sel;
  logic [5:0] reg_raddr_a, reg_raddr_b;
  logic       reg_we, reg_wsel;
  logic [3:0] alu_op;
  logic       halted, illegal, bus_err;

  int total = 0;
  int bad   = 0;

  out_t  exp_q[$];
  string name_q[$];
  out_t  mon_exp;
  out_t  mon_act;
  string mon_name;

  always #5 clk = ~clk;

  ctl_seq #(
    .WIDTH(16), .REGW(6), .OPW(4), .ALU_OPS(8), .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ir           (ir),
    .a_zero       (a_zero),
    .mem_ready    (mem_ready),
    .pc_reset     (pc_reset),
    .pc_inc       (pc_inc),
    .pc_inc2      (pc_inc2),
    .pc_load      (pc_load),
    .ir_load      (ir_load),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .reg_raddr_a  (reg_raddr_a),
    .reg_raddr_b  (reg_raddr_b),
    .reg_we       (reg_we),
    .reg_wsel     (reg_wsel),
    .alu_op       (alu_op),
    .halted       (halted),
    .illegal      (illegal),
    .bus_err      (bus_err)
  );

  // Monitor: one expected vector per stimulus cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {pc_reset, pc_inc, pc_inc2, pc_load, ir_load, mem_req, mem_we,
                  mem_addr_sel, reg_raddr_a, reg_raddr_b, reg_we, reg_wsel,
                  alu_op, halted, illegal, bus_err};
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL %s: got %b want %b", mon_name, mon_act, mon_exp);
      end
    end
  end

  function automatic out_t base(input logic [15:0] iv);
    out_t e = '0;
    e.raddr_a = iv[11:6];
    e.raddr_b = iv[5:0];
    return e;
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [15:0] iv,
                     input logic az, input logic rdy, input out_t e);
    @(posedge clk);
    #1;
    reset     = rst;
    ir        = iv;
    a_zero    = az;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input logic [15:0] iv);
    out_t e;
    cyc("reset", 1'b1, iv, 1'b0, 1'b1, '0);
    e = base(iv);
    e.pc_reset = 1'b1;
    cyc("pc_reset", 1'b0, iv, 1'b0, 1'b0, e);
  endtask

  task automatic fetch_decode(input string tag, input logic [15:0] iv,
                              input int waits);
    out_t e;
    for (int i = 0; i < waits; i++) begin
      e = base(iv);
      e.mem_req = 1'b1;
      cyc({tag, " fetch wait"}, 1'b0, iv, 1'b0, 1'b0, e);
    end
    e = base(iv);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    cyc({tag, " fetch"}, 1'b0, iv, 1'b0, 1'b1, e);
    // mem_ready high while no request is pending must have no effect
    e = base(iv);
    cyc({tag, " decode"}, 1'b0, iv, 1'b0, 1'b1, e);
  endtask

  task automatic alu_instr(input string tag, input logic [15:0] iv);
    out_t e;
    fetch_decode(tag, iv, 0);
    e = base(iv);
    e.reg_we = 1'b1;
    e.pc_inc = 1'b1;
    e.alu_op = iv[15:12];
    cyc({tag, " exec"}, 1'b0, iv, 1'b0, 1'b0, e);
  endtask

  task automatic halt_cycles(input string tag, input logic [15:0] iv,
                             input logic ill, input logic berr);
    out_t e;
    for (int i = 0; i < 3; i++) begin
      e = base(iv);
      e.halted  = 1'b1;
      e.illegal = ill;
      e.bus_err = berr;
      cyc({tag, " halted"}, 1'b0, iv, 1'b0, 1'b1, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;
    reset     = 1'b1;
    ir        = '0;
    a_zero    = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset then ADD r1,r2: pc_reset cycle 1, ir_load cycle 2, exec cycle 4
    do_reset(16'h0042);
    alu_instr("add", 16'h0042);
    alu_instr("alu op7", 16'h7FFF);

    // LD r3,[r5] with three wait cycles
    fetch_decode("ld", 16'h80C5, 0);
    for (int i = 0; i < 3; i++) begin
      e = base(16'h80C5);
      e.mem_req  = 1'b1;
      e.addr_sel = 2'd2;
      cyc("ld wait", 1'b0, 16'h80C5, 1'b0, 1'b0, e);
    end
    e = base(16'h80C5);
    e.mem_req  = 1'b1;
    e.addr_sel = 2'd2;
    e.reg_we   = 1'b1;
    e.wsel     = 1'b1;
    e.pc_inc   = 1'b1;
    cyc("ld ready", 1'b0, 16'h80C5, 1'b0, 1'b1, e);

    // ST [r6],r4 with one wait cycle
    fetch_decode("st", 16'h9106, 0);
    e = base(16'h9106);
    e.mem_req  = 1'b1;
    e.mem_we   = 1'b1;
    e.addr_sel = 2'd2;
    cyc("st wait", 1'b0, 16'h9106, 1'b0, 1'b0, e);
    e.pc_inc = 1'b1;
    cyc("st ready", 1'b0, 16'h9106, 1'b0, 1'b1, e);

    // LI r2 with a waited fetch and a waited immediate read
    fetch_decode("li", 16'hA080, 1);
    e = base(16'hA080);
    e.mem_req  = 1'b1;
    e.addr_sel = 2'd1;
    cyc("li wait", 1'b0, 16'hA080, 1'b0, 1'b0, e);
    e.reg_we  = 1'b1;
    e.wsel    = 1'b1;
    e.pc_inc2 = 1'b1;
    cyc("li ready", 1'b0, 16'hA080, 1'b0, 1'b1, e);

    // JZ taken, then not taken
    fetch_decode("jz1", 16'hB042, 0);
    e = base(16'hB042);
    e.pc_load = 1'b1;
    cyc("jz taken", 1'b0, 16'hB042, 1'b1, 1'b1, e);
    fetch_decode("jz0", 16'hB042, 0);
    e = base(16'hB042);
    e.pc_inc = 1'b1;
    cyc("jz not taken", 1'b0, 16'hB042, 1'b0, 1'b1, e);

    // SYS halts without illegal; no further requests even with ready high
    fetch_decode("sys", 16'hC000, 0);
    halt_cycles("sys", 16'hC000, 1'b0, 1'b0);

    // Undefined opcode halts and flags illegal; reset clears it
    do_reset(16'hF000);
    fetch_decode("bad op", 16'hF000, 0);
    halt_cycles("bad op", 16'hF000, 1'b1, 1'b0);

    // Fetch never completes: bus_err after four waiting cycles
    do_reset(16'h0042);
    for (int i = 0; i < 4; i++) begin
      e = base(16'h0042);
      e.mem_req = 1'b1;
      cyc("timeout wait", 1'b0, 16'h0042, 1'b0, 1'b0, e);
    end
    halt_cycles("timeout", 16'h0042, 1'b0, 1'b1);

    // Reset in the middle of a pending fetch drops mem_req immediately
    do_reset(16'h0042);
    e = base(16'h0042);
    e.mem_req = 1'b1;
    cyc("pending fetch", 1'b0, 16'h0042, 1'b0, 1'b0, e);
    cyc("reset mid fetch", 1'b1, 16'h0042, 1'b0, 1'b0, '0);
    e = base(16'h0042);
    e.pc_reset = 1'b1;
    cyc("pc_reset after mid", 1'b0, 16'h0042, 1'b0, 1'b0, e);
    alu_instr("add again", 16'h0042);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctl_seq.md
# ctl_seq

Parametrised multicycle control sequencer for the IDIOT-family processor; successor to the fixed 16-bit control FSM. It drives the register file, ALU, PC and memory port of the datapath. The generation step over the fixed FSM: it is generic in word width, register-address width and opcode width; memory access uses a `mem_req`/`mem_ready` handshake with a bus-error timeout, replacing fixed wait cycles; and undefined opcodes and explicit halt are handled without terminating simulation.

## Interface
Parameters:
- `WIDTH`, 16, instruction and data word width
- `REGW`, 6, register address width (rd, rs fields)
- `OPW`, 4, opcode field width; `OPW + 2*REGW <= WIDTH` (elaboration error otherwise)
- `ALU_OPS`, 8, opcodes `0 .. ALU_OPS-1` are ALU ops
- `MEM_TIMEOUT`, 255, max cycles `mem_req` may wait for `mem_ready`; 0 disables the timeout

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset
- `ir`  in  WIDTH  current IR contents. Fields: op = top OPW bits, rd = bits [2*REGW-1:REGW], rs = bits [REGW-1:0].
- `a_zero`  in  1  datapath flag: register-port-A value == 0
- `mem_ready`  in  1  memory completes the current request this cycle
- `pc_reset`, `pc_inc`, `pc_inc2`, `pc_load`  out  1 each  PC←0, PC+1, PC+2, PC←port-B value
- `ir_load`  out  1  IR←mem_rdata at clock edge
- `mem_req`, `mem_we`  out  1 each  memory request; write enable
- `mem_addr_sel`  out  2  address select: 0 = PC, 1 = PC+1, 2 = reg port B
- `reg_raddr_a`, `reg_raddr_b`  out  REGW each  read addresses; always rd and rs respectively
- `reg_we`  out  1  register write to rd
- `reg_wsel`  out  1  write-data source: 0 = ALU, 1 = mem_rdata
- `alu_op`  out  OPW  ALU operation select
- `halted`, `illegal`, `bus_err`  out  1 each  sticky status flags

## Operation
- States: S_RESET, S_FETCH, S_DECODE, S_ALU, S_LD, S_ST, S_LI, S_JZ, S_HALT.
- Outputs are a combinational decode of the registered state, `ir`, `a_zero` and `mem_ready`. While `reset` is high, all outputs are 0.
- S_RESET: `pc_reset`=1 → S_FETCH.
- S_FETCH: `mem_req`=1, addr_sel=PC. On `mem_ready`: `ir_load`=1 → S_DECODE.
- S_DECODE, by op:
  - op < ALU_OPS → S_ALU
  - op = ALU_OPS → S_LD
  - op = ALU_OPS+1 → S_ST
  - op = ALU_OPS+2 → S_LI
  - op = ALU_OPS+3 → S_JZ
  - op = ALU_OPS+4 (SYS) → S_HALT
  - any other op → S_HALT and set `illegal`
- S_ALU: `alu_op`=op, `reg_we`=1, wsel=ALU, `pc_inc`=1 → S_FETCH.
- S_LD: `mem_req`, addr_sel=B. On ready: `reg_we`=1, wsel=MEM, `pc_inc`=1 → S_FETCH.
- S_ST: `mem_req`, `mem_we`, addr_sel=B; write data is port A. On ready: `pc_inc`=1 → S_FETCH.
- S_LI: `mem_req`, addr_sel=PC+1. On ready: `reg_we`=1, wsel=MEM, `pc_inc2`=1 → S_FETCH.
- S_JZ: if `a_zero`, `pc_load`=1, else `pc_inc`=1 → S_FETCH.
- S_HALT: `halted`=1; no outputs active; the only exit is `reset`.
- Timeout: a counter counts cycles in any `mem_req` state without `mem_ready`. On reaching MEM_TIMEOUT: set `bus_err` → S_HALT, with `mem_req` dropped the next cycle. The counter clears on every ready and on every state change.
- At most one of the `pc_*` strobes is high in any cycle.

## Timing
- Zero-wait memory (ready in same cycle as req): ALU and JZ instructions take 3 cycles (FETCH, DECODE, EXEC); LD, ST and LI take 3 cycles.
- Each wait cycle adds 1 cycle.
- `mem_req`, `mem_we` and `mem_addr_sel` are held stable from assertion until the ready cycle inclusive.
- Reset mid-access: `mem_req` is 0 in the reset cycle; state = S_RESET on the next edge; `halted`, `illegal` and `bus_err` are cleared.
- `mem_ready` while `mem_req`=0 is ignored.

## Structure
- Package `ctl_pkg` holds:
  - state enum
  - opcode offsets relative to ALU_OPS (LD, ST, LI, JZ, SYS)
  - `mem_addr_sel` encodings
  - `reg_wsel` encodings
- Sub-module `mem_wait_timer`: parametrised by MEM_TIMEOUT; inputs `clk`, `reset`, `clr`, `run`; output `expired`.

## Test plan
- Reset, then ADD (ir=0x0042), zero-wait memory → `pc_reset` in cycle 1; `ir_load` cycle 2; `reg_we`, `alu_op`=0 and `pc_inc` in cycle 4; `reg_raddr_a`=1, `reg_raddr_b`=2.
- LD with `mem_ready` delayed 3 cycles → `mem_req`/addr_sel=2 held 4 cycles; `reg_we`+wsel=1 only in the ready cycle.
- LI (op 10) → addr_sel=1 during the access; `pc_inc2`=1 once; `pc_inc`=0 throughout.
- JZ with `a_zero`=1 → `pc_load`=1; repeat with `a_zero`=0 → `pc_inc`=1.
- ir=0xF000 → `illegal`=1, `halted`=1, no further `mem_req` until reset; SYS op 12 → `halted`=1, `illegal`=0.
- MEM_TIMEOUT=4 with `mem_ready` held 0 → `bus_err` after 4 waiting cycles; `reset` asserted during a pending fetch → `mem_req`=0 the same cycle.
